// File: rtl/coherence_bus_arbiter.sv
// -----------------------------------------------------------------------------
// coherence_bus_arbiter
//
// Owns the single shared snooping bus between the per-core L1 controllers and
// the shared L2. Each transaction goes through these steps:
//   1. One pending request is granted, round-robin.
//   2. Except for writebacks, the request is broadcast as a snoop to every
//      other core, and the snoop responses are collected.
//   3. The transaction completes in one of three ways: cache-to-cache
//      transfer, L2 read/write, or no data movement (upgrade).
//   4. A one-cycle response is returned to the requester.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   req_valid       per-core request valid
//   req_ready       per-core one-hot accept pulse (combinational, IDLE only)
//   req_addr        per-core line address, core i at [i*ADDR_W +: ADDR_W]
//   req_type        per-core request type: 0 RD, 1 RDX, 2 UPGR, 3 WB
//   req_data        per-core writeback data
//   resp_valid      per-core one-cycle response pulse
//   resp_data       response data, common to all cores
//   resp_shared     line is held by another core (RD only)
//   snoop_valid     per-core snoop strobe (never to the requester)
//   snoop_addr      snooped line address
//   snoop_req       snooped request type
//   snoop_shared    per-core "I hold a valid copy", sampled in the snoop cycle
//   snoop_data      per-core snoop data, valid with snoop_shared
//   l2_req_*        L2 request channel, held stable until l2_req_ready
//   l2_resp_*       L2 read data return
// -----------------------------------------------------------------------------
module coherence_bus_arbiter #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N_CORES-1:0]        req_valid,
   output logic [N_CORES-1:0]        req_ready,
   input  logic [N_CORES*ADDR_W-1:0] req_addr,
   input  logic [N_CORES*2-1:0]      req_type,
   input  logic [N_CORES*DATA_W-1:0] req_data,
   output logic [N_CORES-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_shared,
   output logic [N_CORES-1:0]        snoop_valid,
   output logic [ADDR_W-1:0]         snoop_addr,
   output logic [1:0]                snoop_req,
   input  logic [N_CORES-1:0]        snoop_shared,
   input  logic [N_CORES*DATA_W-1:0] snoop_data,
   output logic                      l2_req_valid,
   input  logic                      l2_req_ready,
   output logic [ADDR_W-1:0]         l2_req_addr,
   output logic                      l2_req_we,
   output logic [DATA_W-1:0]         l2_req_data,
   input  logic                      l2_resp_valid,
   input  logic [DATA_W-1:0]         l2_resp_data
);

   localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   localparam logic [1:0] REQ_RD   = 2'd0;
   localparam logic [1:0] REQ_RDX  = 2'd1;
   localparam logic [1:0] REQ_UPGR = 2'd2;
   localparam logic [1:0] REQ_WB   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNOOP   = 3'd1,
      ST_L2_REQ  = 3'd2,
      ST_L2_WAIT = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   // Transaction state
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [IDX_W-1:0]   winner_q, winner_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [1:0]         type_q, type_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               hit_q, hit_d;

   // Registered outputs
   logic [N_CORES-1:0] snoop_valid_q, snoop_valid_d;
   logic [ADDR_W-1:0]  snoop_addr_q, snoop_addr_d;
   logic [1:0]         snoop_req_q, snoop_req_d;
   logic               l2_req_valid_q, l2_req_valid_d;
   logic [ADDR_W-1:0]  l2_req_addr_q, l2_req_addr_d;
   logic               l2_req_we_q, l2_req_we_d;
   logic [DATA_W-1:0]  l2_req_data_q, l2_req_data_d;
   logic [N_CORES-1:0] resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]  resp_data_q, resp_data_d;
   logic               resp_shared_q, resp_shared_d;

   // Arbitration and snoop-collection results
   logic               grant_found_s;
   logic [IDX_W-1:0]   grant_idx_s;
   logic [ADDR_W-1:0]  grant_addr_s;
   logic [1:0]         grant_type_s;
   logic [DATA_W-1:0]  grant_data_s;
   logic [N_CORES-1:0] snoop_mask_s;
   logic               snoop_hit_s;
   logic               snoop_sel_found_s;
   logic [DATA_W-1:0]  snoop_sel_data_s;

   // Converts a core index into its one-hot core mask.
   function automatic logic [N_CORES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N_CORES-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_CORES; i++) begin
         oh[i] = (idx == IDX_W'(i));
      end
      return oh;
   endfunction

   // Round-robin search. It starts at last_grant+1 and wraps around, and it
   // also muxes out the winner's request fields.
   always_comb begin
      int               cand_raw;
      logic [IDX_W-1:0] cand_idx;
      cand_raw      = 0;
      cand_idx      = '0;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      grant_addr_s  = '0;
      grant_type_s  = REQ_RD;
      grant_data_s  = '0;
      for (int i = 0; i < N_CORES; i++) begin
         cand_raw = int'(last_grant_q) + 1 + i;
         cand_idx = (cand_raw >= N_CORES) ? IDX_W'(cand_raw - N_CORES) : IDX_W'(cand_raw);
         if (!grant_found_s && req_valid[cand_idx]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_idx;
            grant_addr_s  = req_addr[int'(cand_idx)*ADDR_W +: ADDR_W];
            grant_type_s  = req_type[int'(cand_idx)*2 +: 2];
            grant_data_s  = req_data[int'(cand_idx)*DATA_W +: DATA_W];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // The accept pulse is combinational and is only asserted in IDLE. Gating
   // with reset_n keeps it low while the block is held in reset.
   always_comb begin
      if ((state_q == ST_IDLE) && grant_found_s && reset_n) begin
         req_ready = idx_to_onehot(grant_idx_s);
      end else begin
         req_ready = '0;
      end
   end

   // Snoop collection. The requester's own snoop_shared is masked out. Data
   // comes from the lowest-index sharer; all valid copies hold the same data.
   always_comb begin
      snoop_mask_s      = ~idx_to_onehot(winner_q);
      snoop_hit_s       = |(snoop_shared & snoop_mask_s);
      snoop_sel_found_s = 1'b0;
      snoop_sel_data_s  = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (!snoop_sel_found_s && snoop_shared[i] && snoop_mask_s[i]) begin
            snoop_sel_found_s = 1'b1;
            snoop_sel_data_s  = snoop_data[i*DATA_W +: DATA_W];
         end else begin
            snoop_sel_found_s = snoop_sel_found_s;
         end
      end
   end

   // Next-state and latch updates for the transaction FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      winner_d     = winner_q;
      addr_d       = addr_q;
      type_d       = type_q;
      data_d       = data_q;
      hit_d        = hit_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_found_s) begin
               winner_d = grant_idx_s;
               addr_d   = grant_addr_s;
               type_d   = grant_type_s;
               data_d   = (grant_type_s == REQ_WB) ? grant_data_s : '0;
               hit_d    = 1'b0;
               state_d  = (grant_type_s == REQ_WB) ? ST_L2_REQ : ST_SNOOP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SNOOP: begin
            hit_d  = snoop_hit_s;
            data_d = snoop_hit_s ? snoop_sel_data_s : '0;
            if (type_q == REQ_UPGR) begin
               state_d = ST_RESP;
            end else if (snoop_hit_s) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_L2_REQ;
            end
         end
         ST_L2_REQ: begin
            if (l2_req_ready) begin
               state_d = (type_q == REQ_WB) ? ST_RESP : ST_L2_WAIT;
            end else begin
               state_d = ST_L2_REQ;
            end
         end
         ST_L2_WAIT: begin
            if (l2_resp_valid) begin
               data_d  = l2_resp_data;
               state_d = ST_RESP;
            end else begin
               state_d = ST_L2_WAIT;
            end
         end
         ST_RESP: begin
            last_grant_d = winner_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output registers are loaded from the next state. Each strobe is
   // therefore a clean flop output during the cycle its state is occupied.
   always_comb begin
      snoop_valid_d  = '0;
      snoop_addr_d   = '0;
      snoop_req_d    = 2'd0;
      l2_req_valid_d = 1'b0;
      l2_req_addr_d  = '0;
      l2_req_we_d    = 1'b0;
      l2_req_data_d  = '0;
      resp_valid_d   = '0;
      resp_data_d    = '0;
      resp_shared_d  = 1'b0;
      case (state_d)
         ST_SNOOP: begin
            snoop_valid_d = ~idx_to_onehot(winner_d);
            snoop_addr_d  = addr_d;
            snoop_req_d   = type_d;
         end
         ST_L2_REQ: begin
            l2_req_valid_d = 1'b1;
            l2_req_addr_d  = addr_d;
            l2_req_we_d    = (type_d == REQ_WB);
            l2_req_data_d  = (type_d == REQ_WB) ? data_d : '0;
         end
         ST_RESP: begin
            resp_valid_d  = idx_to_onehot(winner_d);
            resp_data_d   = ((type_d == REQ_RD) || (type_d == REQ_RDX)) ? data_d : '0;
            resp_shared_d = (type_d == REQ_RD) && hit_d;
         end
         default: begin
            snoop_valid_d = '0;
         end
      endcase
   end

   // State and output flops. An asynchronous reset abandons any transaction
   // that is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         last_grant_q   <= IDX_W'(N_CORES - 1);
         winner_q       <= '0;
         addr_q         <= '0;
         type_q         <= 2'd0;
         data_q         <= '0;
         hit_q          <= 1'b0;
         snoop_valid_q  <= '0;
         snoop_addr_q   <= '0;
         snoop_req_q    <= 2'd0;
         l2_req_valid_q <= 1'b0;
         l2_req_addr_q  <= '0;
         l2_req_we_q    <= 1'b0;
         l2_req_data_q  <= '0;
         resp_valid_q   <= '0;
         resp_data_q    <= '0;
         resp_shared_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         winner_q       <= winner_d;
         addr_q         <= addr_d;
         type_q         <= type_d;
         data_q         <= data_d;
         hit_q          <= hit_d;
         snoop_valid_q  <= snoop_valid_d;
         snoop_addr_q   <= snoop_addr_d;
         snoop_req_q    <= snoop_req_d;
         l2_req_valid_q <= l2_req_valid_d;
         l2_req_addr_q  <= l2_req_addr_d;
         l2_req_we_q    <= l2_req_we_d;
         l2_req_data_q  <= l2_req_data_d;
         resp_valid_q   <= resp_valid_d;
         resp_data_q    <= resp_data_d;
         resp_shared_q  <= resp_shared_d;
      end
   end

   assign snoop_valid  = snoop_valid_q;
   assign snoop_addr   = snoop_addr_q;
   assign snoop_req    = snoop_req_q;
   assign l2_req_valid = l2_req_valid_q;
   assign l2_req_addr  = l2_req_addr_q;
   assign l2_req_we    = l2_req_we_q;
   assign l2_req_data  = l2_req_data_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_shared  = resp_shared_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_coherence_bus_arbiter
//
// Directed bench for coherence_bus_arbiter. The main flow drives requests,
// snoop responses and the L2 side. Each expected response (core, data,
// shared, latency from grant) is pushed to a scoreboard when the request is
// driven. A negedge monitor pops the scoreboard on every resp_valid pulse and
// records the grant order.
// -----------------------------------------------------------------------------
module tb_coherence_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 1;

   localparam logic [1:0] RD   = 2'd0;
   localparam logic [1:0] RDX  = 2'd1;
   localparam logic [1:0] UPGR = 2'd2;
   localparam logic [1:0] WB   = 2'd3;

   logic              clk;
   logic              reset_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_addr;
   logic [N*2-1:0]    req_type;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      resp_valid;
   logic [DW-1:0]     resp_data;
   logic              resp_shared;
   logic [N-1:0]      snoop_valid;
   logic [AW-1:0]     snoop_addr;
   logic [1:0]        snoop_req;
   logic [N-1:0]      snoop_shared;
   logic [N*DW-1:0]   snoop_data;
   logic              l2_req_valid;
   logic              l2_req_ready;
   logic [AW-1:0]     l2_req_addr;
   logic              l2_req_we;
   logic [DW-1:0]     l2_req_data;
   logic              l2_resp_valid;
   logic [DW-1:0]     l2_resp_data;

   typedef struct {
      int   core;
      logic data;
      logic shared;
      int   lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   grant_q[$];
   int   grant_cyc[N];
   int   cyc = 0;
   int   l2_cycles = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   l2_base;
   int   rr_exp[4] = '{0, 1, 3, 0};

   coherence_bus_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_type      (req_type),
      .req_data      (req_data),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_shared   (resp_shared),
      .snoop_valid   (snoop_valid),
      .snoop_addr    (snoop_addr),
      .snoop_req     (snoop_req),
      .snoop_shared  (snoop_shared),
      .snoop_data    (snoop_data),
      .l2_req_valid  (l2_req_valid),
      .l2_req_ready  (l2_req_ready),
      .l2_req_addr   (l2_req_addr),
      .l2_req_we     (l2_req_we),
      .l2_req_data   (l2_req_data),
      .l2_resp_valid (l2_resp_valid),
      .l2_resp_data  (l2_resp_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: grant order and timing, L2 activity, and the response scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (req_ready != 4'b0000) begin
            check_eq("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            for (int i = 0; i < N; i++) begin
               if (req_ready[i]) begin
                  grant_cyc[i] = cyc;
                  grant_q.push_back(i);
               end
            end
         end
         if (l2_req_valid) l2_cycles++;
         if (resp_valid != 4'b0000) begin
            if (sb.size() == 0) begin
               check_eq("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check_eq("resp_core", 32'(resp_valid), 32'd1 << mon_e.core);
               check_eq("resp_data", 32'(resp_data), 32'(mon_e.data));
               check_eq("resp_shared", 32'(resp_shared), 32'(mon_e.shared));
               check_eq("resp_latency", 32'(cyc - grant_cyc[mon_e.core]), 32'(mon_e.lat));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int core, input logic d, input logic sh, input int lat);
      exp_t e;
      e.core = core; e.data = d; e.shared = sh; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic drive_req(input int core, input logic [1:0] typ, input logic [AW-1:0] addr,
                            input logic d);
      req_type[core*2 +: 2]   = typ;
      req_addr[core*AW +: AW] = addr;
      req_data[core]          = d;
      req_valid[core]         = 1'b1;
   endtask

   // Waits for the core's accept pulse, then drops its request. Returns one
   // cycle after the grant, which is the snoop cycle.
   task automatic wait_grant(input int core);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         if (req_ready[core]) seen = 1'b1;
         n++;
      end
      check_eq("grant_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      req_valid[core] = 1'b0;
   endtask

   // Acts as the L2: checks the request, stalls it for `stall` cycles and,
   // for reads, returns data the cycle after the accept.
   task automatic l2_serve(input int stall, input bit is_read, input logic rdata,
                           input logic [AW-1:0] exp_addr, input logic exp_we, input logic exp_wdata);
      int n;
      n = 0;
      while (!l2_req_valid && n < 20) begin
         tick(1);
         n++;
      end
      check_eq("l2_valid", 32'(l2_req_valid), 32'd1);
      check_eq("l2_addr", 32'(l2_req_addr), 32'(exp_addr));
      check_eq("l2_we", 32'(l2_req_we), 32'(exp_we));
      if (exp_we) check_eq("l2_wdata", 32'(l2_req_data), 32'(exp_wdata));
      for (int s = 0; s < stall; s++) begin
         l2_req_ready = 1'b0;
         tick(1);
         check_eq("l2_hold_valid", 32'(l2_req_valid), 32'd1);
         check_eq("l2_hold_addr", 32'(l2_req_addr), 32'(exp_addr));
      end
      l2_req_ready = 1'b1;
      tick(1);
      l2_req_ready = 1'b0;
      check_eq("l2_drop", 32'(l2_req_valid), 32'd0);
      if (is_read) begin
         l2_resp_valid = 1'b1;
         l2_resp_data  = rdata;
         tick(1);
         l2_resp_valid = 1'b0;
         l2_resp_data  = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick(1);
         n++;
      end
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      sb.delete();
      tick(2);
   endtask

   initial begin
      reset_n       = 1'b0;
      req_valid     = '0;
      req_addr      = '0;
      req_type      = '0;
      req_data      = '0;
      snoop_shared  = '0;
      snoop_data    = '0;
      l2_req_ready  = 1'b0;
      l2_resp_valid = 1'b0;
      l2_resp_data  = '0;
      #2;
      check_eq("reset_outputs", {1'b0, req_ready, resp_valid, resp_data, resp_shared, snoop_valid,
               snoop_addr, snoop_req, l2_req_valid, l2_req_addr, l2_req_we, l2_req_data}, 32'd0);
      tick(3);
      reset_n = 1'b1;
      tick(1);

      // Round-robin: cores 0, 1 and 3 request continuously; all hit in snoop.
      snoop_shared = 4'b1111;
      snoop_data   = 4'b1111;
      grant_q.delete();
      push_exp(0, 1'b1, 1'b1, 2);
      push_exp(1, 1'b1, 1'b1, 2);
      push_exp(3, 1'b1, 1'b1, 2);
      push_exp(0, 1'b1, 1'b1, 2);
      drive_req(0, RD, 6'h01, 1'b0);
      drive_req(1, RD, 6'h02, 1'b0);
      drive_req(3, RD, 6'h03, 1'b0);
      begin
         int n;
         n = 0;
         while (grant_q.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      check_eq("rr_count", 32'(grant_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < grant_q.size()) check_eq("rr_order", 32'(grant_q[i]), 32'(rr_exp[i]));
      end
      drain();
      check_eq("rr_total", 32'(grant_q.size()), 32'd4);

      // Core 2 RD 0x15 with no sharers: L2 read, data 1.
      snoop_shared = 4'b0000;
      snoop_data   = 4'b0000;
      push_exp(2, 1'b1, 1'b0, 4);
      drive_req(2, RD, 6'h15, 1'b0);
      wait_grant(2);
      check_eq("t1_snoop_valid", 32'(snoop_valid), 32'(4'b1011));
      check_eq("t1_snoop_addr", 32'(snoop_addr), 32'h15);
      check_eq("t1_snoop_req", 32'(snoop_req), 32'(RD));
      l2_serve(0, 1'b1, 1'b1, 6'h15, 1'b0, 1'b0);
      drain();

      // Core 1 RD 0x08; cores 2 and 3 share: cache-to-cache transfer.
      snoop_shared = 4'b1100;
      snoop_data   = 4'b1100;
      l2_base = l2_cycles;
      push_exp(1, 1'b1, 1'b1, 2);
      drive_req(1, RD, 6'h08, 1'b0);
      wait_grant(1);
      check_eq("t3_snoop_valid", 32'(snoop_valid), 32'(4'b1101));
      check_eq("t3_snoop_addr", 32'(snoop_addr), 32'h08);
      drain();
      check_eq("t3_no_l2", 32'(l2_cycles - l2_base), 32'd0);

      // Core 2 RDX 0x2A; core 0 shares: data 1, but resp_shared stays 0 for RDX.
      snoop_shared = 4'b0001;
      snoop_data   = 4'b0001;
      l2_base = l2_cycles;
      push_exp(2, 1'b1, 1'b0, 2);
      drive_req(2, RDX, 6'h2A, 1'b0);
      wait_grant(2);
      check_eq("rdx_snoop_req", 32'(snoop_req), 32'(RDX));
      drain();
      check_eq("rdx_no_l2", 32'(l2_cycles - l2_base), 32'd0);

      // Core 0 UPGR: snoop to cores 1-3, no data and no L2 access.
      snoop_shared = 4'b1110;
      snoop_data   = 4'b1110;
      l2_base = l2_cycles;
      push_exp(0, 1'b0, 1'b0, 2);
      drive_req(0, UPGR, 6'h3F, 1'b0);
      wait_grant(0);
      check_eq("upgr_snoop_valid", 32'(snoop_valid), 32'(4'b1110));
      check_eq("upgr_snoop_req", 32'(snoop_req), 32'(UPGR));
      drain();
      check_eq("upgr_no_l2", 32'(l2_cycles - l2_base), 32'd0);

      // Core 0 WB 0x3F with data 1: no snoop, L2 write stalled for 3 cycles.
      snoop_shared = 4'b0000;
      snoop_data   = 4'b0000;
      push_exp(0, 1'b0, 1'b0, 5);
      drive_req(0, WB, 6'h3F, 1'b1);
      wait_grant(0);
      check_eq("wb_no_snoop", 32'(snoop_valid), 32'd0);
      l2_serve(3, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b1);
      drain();

      // Reset during L2_WAIT abandons core 1's read. After release, core 0 must
      // win over core 3.
      drive_req(1, RD, 6'h11, 1'b0);
      wait_grant(1);
      tick(1);
      l2_req_ready = 1'b1;
      tick(1);
      l2_req_ready = 1'b0;
      drive_req(0, RD, 6'h01, 1'b0);
      drive_req(3, RD, 6'h3C, 1'b0);
      reset_n = 1'b0;
      #1;
      check_eq("midrst_outputs", {1'b0, req_ready, resp_valid, resp_data, resp_shared, snoop_valid,
               snoop_addr, snoop_req, l2_req_valid, l2_req_addr, l2_req_we, l2_req_data}, 32'd0);
      sb.delete();
      // Core 3's own snoop_shared is stuck high from here on.
      snoop_shared = 4'b1000;
      snoop_data   = 4'b1000;
      push_exp(0, 1'b1, 1'b1, 2);
      push_exp(3, 1'b0, 1'b0, 4);
      tick(2);
      reset_n = 1'b1;
      #1;
      check_eq("post_rst_priority", 32'(req_ready), 32'(4'b0001));
      wait_grant(0);
      check_eq("post_rst_snoop", 32'(snoop_valid), 32'(4'b1110));
      wait_grant(3);
      check_eq("self_snoop_masked", 32'(snoop_valid), 32'(4'b0111));
      l2_serve(0, 1'b1, 1'b0, 6'h3C, 1'b0, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
- Owns the single shared snooping bus between the per-core L1 blocks and the shared L2.
- Accepts bus requests from N_CORES L1 controllers and grants one at a time, round-robin.
- Broadcasts the granted request as a snoop to every other core and collects the snoop responses.
- Completes the transaction by cache-to-cache transfer, by L2 read/write, or by no data movement (upgrade), then returns a response to the requester.

Parameters:
- N_CORES, 4, number of L1 requesters.
- ADDR_W, 6, line address width (address bits minus offset bits).
- DATA_W, 1, cacheline data width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_CORES  per-core bus request valid.
- req_ready  out  N_CORES  per-core request accept; one-hot pulse.
- req_addr  in  N_CORES*ADDR_W  per-core line address; core i at [i*ADDR_W +: ADDR_W].
- req_type  in  N_CORES*2  per-core bus_req_t: 0 RD, 1 RDX, 2 UPGR, 3 WB.
- req_data  in  N_CORES*DATA_W  per-core writeback data.
- resp_valid  out  N_CORES  per-core one-cycle response pulse.
- resp_data  out  DATA_W  response data, common to all cores.
- resp_shared  out  1  line is held by another core; common.
- snoop_valid  out  N_CORES  per-core snoop strobe.
- snoop_addr  out  ADDR_W  snooped address, common.
- snoop_req  out  2  snooped request type, common.
- snoop_shared  in  N_CORES  per-core "I hold a valid copy", combinational response in the snoop_valid cycle.
- snoop_data  in  N_CORES*DATA_W  per-core snoop data, valid with snoop_shared.
- l2_req_valid  out  1  L2 request valid.
- l2_req_ready  in  1  L2 request accept.
- l2_req_addr  out  ADDR_W  L2 address.
- l2_req_we  out  1  1 = write (WB), 0 = read.
- l2_req_data  out  DATA_W  L2 write data.
- l2_resp_valid  in  1  L2 read data valid.
- l2_resp_data  in  DATA_W  L2 read data.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Round-robin pointer last_grant resets to N_CORES-1, so core 0 has first priority.
  - Reset mid-transaction abandons the transaction with no response. Requesters re-issue.
- FSM states: IDLE, SNOOP, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching from last_grant+1 upward with wrap-around.
  - req_ready[winner] is asserted combinationally in that cycle, and only in IDLE.
  - addr, type and data of the winner are latched, along with the winner index.
  - WB goes to L2_REQ. Every other type goes to SNOOP.
- SNOOP (exactly 1 cycle):
  - snoop_valid is asserted to all cores except the winner; snoop_addr and snoop_req are driven from the latch.
  - Sample hit = OR of snoop_shared over the non-winner cores. The winner's own snoop_shared is masked.
  - Sample data = snoop_data of the lowest-index non-winner core with snoop_shared set. All valid MOESI copies hold identical data.
  - Next state:
    - UPGR goes to RESP.
    - RD or RDX with hit goes to RESP (cache-to-cache transfer, no L2 access).
    - RD or RDX without hit goes to L2_REQ.
- L2_REQ:
  - l2_req_valid=1 with address and data held stable until l2_req_ready.
  - l2_req_we=1 for WB, 0 otherwise.
  - On accept, WB goes to RESP and RD/RDX goes to L2_WAIT.
- L2_WAIT: on l2_resp_valid, latch l2_resp_data and go to RESP. There is no timeout.
- RESP (1 cycle):
  - resp_valid[winner]=1.
  - resp_data is the latched data (0 for UPGR and WB).
  - resp_shared = hit for RD, 0 for RDX, UPGR and WB.
  - last_grant is updated to winner; next state is IDLE.
  - A new grant is possible in the following cycle.
- Latency from grant cycle T:
  - RD/RDX snoop hit or UPGR: resp at T+2.
  - L2 read with immediate ready and response the cycle after accept: resp at T+4.
  - WB with immediate ready: resp at T+2.
- req_ready is never asserted outside IDLE. Requests that arrive mid-transaction wait.
- snoop_valid, l2_req_valid and resp_valid are registered outputs, glitch-free.
- A core may re-request in the cycle after its own resp_valid. Round-robin still favours other pending cores.

Test Plan:
- Reset, then core 2 issues RD addr 0x15 with no sharers; L2 accepts immediately and returns data 1 one cycle later -> l2_req_valid with we=0, addr 0x15; resp_valid=4'b0100, resp_data=1, resp_shared=0.
- Cores 0, 1 and 3 request simultaneously and repeatedly after reset -> grant order 0, 1, 3, 0; no core is granted twice while another is pending.
- Core 1 issues RD addr 0x08; cores 2 and 3 assert snoop_shared with data 1 -> snoop_valid=4'b1101, no L2 request, resp_data=1, resp_shared=1, resp at T+2.
- Core 0 issues UPGR, then WB with data 1, addr 0x3F -> UPGR: snoop broadcast to cores 1-3, no L2 access, resp at T+2. WB: no snoop, l2_req_we=1, l2_req_data=1, l2_req_valid held through 3 cycles of l2_req_ready=0.
- Deassert reset_n during L2_WAIT -> all outputs 0 immediately; after release, core 0 has priority and the FSM is in IDLE.
- Core 3 issues RD while its own snoop_shared is stuck at 1 -> its own snoop_shared is masked, snoop_valid[3]=0, and L2 read proceeds.
